booth_pp_reducer: RTL
=====================

# booth_pp_reducer

Pipelined reduction stage that sits directly downstream of the radix-8 Booth partial-product multiplexers of the FP16/BF16/INT8 tile-multiply row. Each beat carries 16 lanes, and each lane holds four pre-aligned Booth partial-product rows, their negate-correction bits, the operand exponents and the operand signs. The stage compresses every lane's rows to one 22-bit unsigned mantissa product and forms the unbiased product exponent and sign. It uses a 2-stage valid/ready pipeline and feeds the FMA row adder/normaliser.

## Interface
Parameters:
- LANES, 16, lanes per beat.
- PPW, 24, width of one aligned partial-product row.
- MW, 22, output mantissa-product width.
- EW, 5, input biased exponent width.
- BIAS, 15, exponent bias (15 for FP16; 127 with EW=8 for BF16).

Ports:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, stage can accept a beat.
- in_pp, in, LANES×4×PPW, row k of lane i at [(4i+k)·PPW +: PPW]; rows already shifted by 3k and two's-complement sign-extended to PPW.
- in_neg, in, LANES×3, negate-correction bits of rows 0..2 of lane i at [3i +: 3]; row 3 never negates.
- in_exp_a, in_exp_b, in, LANES×EW, biased exponent fields.
- in_sign_a, in_sign_b, in, LANES, operand signs.
- out_valid, out, 1, result beat valid.
- out_ready, in, 1, downstream accepts.
- out_mant, out, LANES×MW, unsigned mantissa products.
- out_exp, out, LANES×(EW+2), signed unbiased product exponent.
- out_sign, out, LANES, product signs.
- beat_count, out, 16, count of accepted input beats.
- ovf_err, out, 1, present only with the configuration macro (see Configuration).

## Operation
- Per-lane arithmetic: sum = row0 + row1 + row2 + row3 + neg0 + (neg1<<3) + (neg2<<6), computed modulo 2^PPW; out_mant = sum[MW-1:0].
- Exponent: a zero exponent field is treated as 1 (subnormal). out_exp = e_a' + e_b' − BIAS, computed signed in EW+2 bits.
- Sign: out_sign = sign_a ^ sign_b.
- Stage 1: per lane, a 4:2 carry-save compression of the four rows plus the correction word. Sum and carry vectors are registered with exponent and sign. Register s1_valid.
- Stage 2: a carry-propagate add, truncation to MW, and the exponent subtract, all registered. Register s2_valid, which drives out_valid.
- beat_count increments on every in_valid && in_ready and wraps from 0xFFFF to 0.

## Timing
- Latency is 2 cycles from input accept to out_valid, with no stalls.
- Throughput is 1 beat per cycle.
- Ready logic:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 advances.
  - in_ready = (!s1_valid || s2 advances).
  - in_ready is combinational from out_ready. No skid buffer.
- Back-pressure: while out_valid && !out_ready, out_mant, out_exp and out_sign hold stable. Stage 1 fills, then in_ready falls.
- Simultaneous events: an input accept and an output drain in the same cycle are both taken. No beat is lost or duplicated.
- Bubbles: data registers load only on advance; valid bits clear when a stage drains without refill.
- Reset values: out_valid=0, in_ready=1 (combinational after reset), out_mant=0, out_exp=0, out_sign=0, beat_count=0, ovf_err=0.
- Reset mid-operation discards all in-flight beats.

## Configuration
- The macro is BOOTH_PP_REDUCER_OVF_CHECK_EN.
- When defined:
  - ovf_err is a port.
  - Stage 2 sets a sticky ovf_err if any accepted lane has sum[PPW-1:MW] ≠ 0.
  - ovf_err clears only on rst.
- When undefined: the port and its logic are absent, and the upper sum bits are silently dropped.

## Structure
- A shared package holds:
  - LANES, PPW, MW, EW and BIAS defaults.
  - The lane payload typedef (4 rows, neg bits, exponents, signs).
  - The stage-1 carry-save typedef.
- One sub-module, booth_lane_csa: the combinational per-lane 4:2 compressor with correction injection, instantiated LANES times in stage 1.

## Test plan
- Lane 0: row0=0x100000, other rows and neg bits 0, exp 15/15, signs 0/1. Required: out_mant 0x100000, out_exp 15, out_sign 1, out_valid exactly 2 cycles after accept.
- Lane 3: row0=0xFFFFFF, neg0=1, row1=0x000008. Required: out_mant 0x000008; with the macro defined, ovf_err stays 0.
- Subnormal: exp 0/0 in all lanes. Required: out_exp −13 (0x73 in 7 bits).
- Back-pressure:
  - Stream 5 beats while holding out_ready=0 for 4 cycles.
  - Required: in_ready falls after 2 accepts, outputs hold stable, then all 5 beats emerge in order with beat_count=5.
- Overflow (macro defined): lane 7 row3=0x400000, others 0. Required: ovf_err rises with out_valid and stays 1 until rst.
- Reset mid-flight: assert rst with both stages full. Required: out_valid=0 and beat_count=0 immediately (asynchronously); no stale beat appears after release.

Source files
------------

// File: rtl/booth_pp_reducer_pkg.sv
// Shared defaults, lane payload and carry-save types, and small arithmetic
// helpers for the booth_pp_reducer partial-product reduction stage.
package booth_pp_reducer_pkg;

  localparam int LANES_DEF = 16;
  localparam int PPW_DEF   = 24;
  localparam int MW_DEF    = 22;
  localparam int EW_DEF    = 5;
  localparam int BIAS_DEF  = 15;

  // One lane as delivered by the Booth muxes: rows[k] is already shifted by 3k.
  typedef struct packed {
    logic [3:0][PPW_DEF-1:0] rows;
    logic [2:0]              neg;
    logic [EW_DEF-1:0]       exp_a;
    logic [EW_DEF-1:0]       exp_b;
    logic                    sign_a;
    logic                    sign_b;
  } lane_payload_t;

  // Redundant (sum, carry) form of a lane plus the biased exponent sum.
  typedef struct packed {
    logic [PPW_DEF-1:0] sum;
    logic [PPW_DEF-1:0] carry;
    logic [EW_DEF:0]    exp_sum;
    logic               sign;
  } lane_csa_t;

  // Subnormal operands use an effective exponent of 1.
  function automatic logic [EW_DEF-1:0] eff_exp(input logic [EW_DEF-1:0] e);
    return (e == '0) ? EW_DEF'(1) : e;
  endfunction

  // Negate corrections land at the LSB of rows 0..2, i.e. bits 0, 3 and 6.
  function automatic logic [PPW_DEF-1:0] neg_correction(input logic [2:0] neg);
    logic [PPW_DEF-1:0] corr;
    corr    = '0;
    corr[0] = neg[0];
    corr[3] = neg[1];
    corr[6] = neg[2];
    return corr;
  endfunction

  function automatic logic [PPW_DEF-1:0] majority(input logic [PPW_DEF-1:0] a,
                                                  input logic [PPW_DEF-1:0] b,
                                                  input logic [PPW_DEF-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/booth_lane_csa.sv
// Combinational per-lane compressor: four Booth rows plus the negate-correction
// word reduced to a (sum, carry) pair, with exponent sum and product sign.
module booth_lane_csa
  import booth_pp_reducer_pkg::*;
(
  input  lane_payload_t lane,
  output lane_csa_t     csa
);

  logic [PPW_DEF-1:0] corr;
  logic [PPW_DEF-1:0] sum_a;
  logic [PPW_DEF-1:0] carry_a;
  logic [PPW_DEF-1:0] sum_b;
  logic [PPW_DEF-1:0] carry_b;
  logic [PPW_DEF-1:0] sum_c;
  logic [PPW_DEF-1:0] carry_c;

  // Three full-adder levels; every carry shift is modulo 2^PPW, matching the
  // truncating arithmetic of the final carry-propagate add.
  always_comb begin
    corr    = neg_correction(lane.neg);

    sum_a   = lane.rows[0] ^ lane.rows[1] ^ lane.rows[2];
    carry_a = majority(lane.rows[0], lane.rows[1], lane.rows[2]) << 1;

    sum_b   = sum_a ^ carry_a ^ lane.rows[3];
    carry_b = majority(sum_a, carry_a, lane.rows[3]) << 1;

    sum_c   = sum_b ^ carry_b ^ corr;
    carry_c = majority(sum_b, carry_b, corr) << 1;

    csa.sum     = sum_c;
    csa.carry   = carry_c;
    csa.exp_sum = {1'b0, eff_exp(lane.exp_a)} + {1'b0, eff_exp(lane.exp_b)};
    csa.sign    = lane.sign_a ^ lane.sign_b;
  end

endmodule

// File: rtl/booth_pp_reducer.sv
// Two-stage valid/ready reducer: carry-save compression, then CPA and exponent
// unbias. Define BOOTH_PP_REDUCER_OVF_CHECK_EN to add the sticky ovf_err output.
module booth_pp_reducer
  import booth_pp_reducer_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int PPW   = PPW_DEF,
  parameter int MW    = MW_DEF,
  parameter int EW    = EW_DEF,
  parameter int BIAS  = BIAS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*4*PPW-1:0]  in_pp,
  input  logic [LANES*3-1:0]      in_neg,
  input  logic [LANES*EW-1:0]     in_exp_a,
  input  logic [LANES*EW-1:0]     in_exp_b,
  input  logic [LANES-1:0]        in_sign_a,
  input  logic [LANES-1:0]        in_sign_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*MW-1:0]     out_mant,
  output logic [LANES*(EW+2)-1:0] out_exp,
  output logic [LANES-1:0]        out_sign,
  output logic [15:0]             beat_count
`ifdef BOOTH_PP_REDUCER_OVF_CHECK_EN
  ,
  output logic                    ovf_err
`endif
);

  localparam int XW = EW + 2;
  localparam logic [XW-1:0] EXP_BIAS = XW'(BIAS);

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;
  logic in_fire;

  lane_payload_t lane_in  [LANES];
  lane_csa_t     csa_comb [LANES];
  lane_csa_t     s1_data  [LANES];

  logic [PPW-1:0]         full_sum [LANES];
  logic [LANES*MW-1:0]    mant_next;
  logic [LANES*XW-1:0]    exp_next;
  logic [LANES-1:0]       sign_next;
`ifdef BOOTH_PP_REDUCER_OVF_CHECK_EN
  logic [LANES-1:0]       lane_ovf;
`endif

  // Handshake is purely combinational from out_ready; no skid buffer.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_in[i] = {in_pp[4*i*PPW +: 4*PPW],
                         in_neg[3*i +: 3],
                         in_exp_a[EW*i +: EW],
                         in_exp_b[EW*i +: EW],
                         in_sign_a[i],
                         in_sign_b[i]};

    booth_lane_csa u_csa (
      .lane (lane_in[i]),
      .csa  (csa_comb[i])
    );

    assign full_sum[i]             = s1_data[i].sum + s1_data[i].carry;
    assign mant_next[i*MW +: MW]   = full_sum[i][MW-1:0];
    assign exp_next[i*XW +: XW]    = {1'b0, s1_data[i].exp_sum} - EXP_BIAS;
    assign sign_next[i]            = s1_data[i].sign;
`ifdef BOOTH_PP_REDUCER_OVF_CHECK_EN
    assign lane_ovf[i]             = |full_sum[i][PPW-1:MW];
`endif
  end

  // Stage 1 holds the carry-save form; stage 2 holds the resolved outputs.
  // Data registers move only on advance so a stalled beat stays put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1_data    <= '{default: '0};
      out_mant   <= '0;
      out_exp    <= '0;
      out_sign   <= '0;
      beat_count <= '0;
`ifdef BOOTH_PP_REDUCER_OVF_CHECK_EN
      ovf_err    <= 1'b0;
`endif
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data <= csa_comb;
        end
      end

      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_mant <= mant_next;
          out_exp  <= exp_next;
          out_sign <= sign_next;
`ifdef BOOTH_PP_REDUCER_OVF_CHECK_EN
          if (|lane_ovf) begin
            ovf_err <= 1'b1;
          end
`endif
        end
      end

      if (in_fire) begin
        beat_count <= beat_count + 16'd1;
      end
    end
  end

endmodule
